// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message-schedule block.
// Contents:
//   NUM_ROUNDS, WORD_W   fixed SHA-256 geometry
//   sched_state_t        schedule FSM states {IDLE, RUN}
//   K[0:63]              round constants
//   ror32                32-bit rotate right
//   small_sigma0/1       message-expansion mixing functions
package sha256_pkg;

    localparam int NUM_ROUNDS = 64;
    localparam int WORD_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotation via a doubled word so the shift amount needs no width juggling.
    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant ROM, purely combinational.
// Ports:
//   addr_i  in   6   round index
//   k_o     out  32  K[addr_i]
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  addr_i,
    output logic [31:0] k_o
);

    assign k_o = K[addr_i];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts one 512-bit block and streams 64 (W[t], K[t])
// pairs with valid/ready handshake. W[t] is expanded in a 16-word sliding window.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   blk_valid, blk_data         block input (M[0] in the top 32 bits)
//   blk_ready                   block accepted when blk_valid && blk_ready
//   out_ready                   downstream consumes the current pair
//   out_valid, w_i, k_i         current schedule word and round constant
//   round_idx                   current round 0..63
//   out_first, out_last         round 0 / round 63 markers
//   busy                        block in progress
//
// State table
//   IDLE | waiting for a block, blk_ready high
//   RUN  | streaming rounds 0..63, out_valid high
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic [511:0] blk_data,
    output logic         blk_ready,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [31:0]  w_i,
    output logic [31:0]  k_i,
    output logic [5:0]   round_idx,
    output logic         out_first,
    output logic         out_last,
    output logic         busy
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    sched_state_t state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [31:0]  win_q [16];
    logic [31:0]  win_d [16];
    logic [31:0]  w_next;

    // W[t+16] from the window holding W[t..t+15].
    assign w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = blk_data[511 - 32*i -: 32];
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 6'd1;
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = w_next;
                    if (cnt_q == LAST_ROUND) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    sha256_k_rom u_k_rom (
        .addr_i (cnt_q),
        .k_o    (k_i)
    );

    // Every output decodes registered state only.
    assign blk_ready = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign w_i       = win_q[0];
    assign round_idx = cnt_q;
    assign out_first = out_valid && (cnt_q == 6'd0);
    assign out_last  = out_valid && (cnt_q == LAST_ROUND);

endmodule
